// File: rtl/modn_counter_pkg.sv
// Shared types and next-count arithmetic for the modulo-N up/down counter family.
// Latency: none, pure functions and types.
// Backpressure: not applicable.
package modn_counter_pkg;

    typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;

    // Wide enough for WIDTH up to 32 plus one headroom bit, so MODULUS = 2**WIDTH
    // is representable and the wrap compare never overflows.
    localparam int CALC_W = 33;

    // Wrapped successor/predecessor of q within 0..modulus-1.
    function automatic logic [CALC_W-1:0] modn_next(
        input logic [CALC_W-1:0] q,
        input dir_e              up,
        input logic [CALC_W-1:0] modulus
    );
        logic [CALC_W-1:0] r;
        if (up == DIR_UP) begin
            r = (q == modulus - CALC_W'(1)) ? '0 : q + CALC_W'(1);
        end else begin
            r = (q == '0) ? modulus - CALC_W'(1) : q - CALC_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/modn_next_calc.sv
// Combinational next-count and terminal-count detect for a modulo-MODULUS digit.
// Latency: zero, purely combinational.
// Backpressure: none; TC is the carry that gates the next stage's count.
module modn_next_calc
    import modn_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up,
    input  logic             enable,
    input  logic             ci,
    input  logic             load,
    output logic [WIDTH-1:0] next_q,
    output logic             tc
);

    localparam int               EXT_W   = WIDTH + 1;
    localparam logic [EXT_W-1:0] MOD_EXT = EXT_W'(MODULUS);
    localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MODULUS - 1);

    dir_e             dir;
    logic [EXT_W-1:0] q_ext;
    logic             at_end;

    // Wrapped next value (computed with a spare top bit) and end-of-range detect.
    always_comb begin
        dir    = dir_e'(up);
        q_ext  = {1'b0, q};
        next_q = WIDTH'(modn_next(CALC_W'(q_ext), dir, CALC_W'(MOD_EXT)));
        at_end = (dir == DIR_UP) ? (q == Q_MAX) : (q == '0);
        tc     = enable & ci & ~load & at_end;
    end

endmodule

// File: rtl/modn_updown_counter.sv
// Loadable modulo-MODULUS up/down counter with enable, carry-in and cascade TC.
// Latency: Q and Load_err update one cycle after the qualifying edge; TC is combinational.
// Backpressure: none; CI/TC chain cascades digits synchronously without ripple.
// Optional: MODN_STICKY_OVF_EN adds a sticky wrap flag Ovf with clear input Ovf_clr.
module modn_updown_counter
    import modn_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             CLK,
    input  logic             MR_N,
    input  logic             Load,
    input  logic [WIDTH-1:0] P,
    input  logic             Enable,
    input  logic             CI,
    input  logic             Up,
`ifdef MODN_STICKY_OVF_EN
    input  logic             Ovf_clr,
    output logic             Ovf,
`endif
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             Load_err
);

    localparam int               EXT_W   = WIDTH + 1;
    localparam logic [EXT_W-1:0] MOD_EXT = EXT_W'(MODULUS);
    localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MODULUS - 1);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $fatal(1, "modn_updown_counter: WIDTH %0d outside 1..32", WIDTH);
    end
    if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
        $fatal(1, "modn_updown_counter: MODULUS %0d outside 2..2**%0d", MODULUS, WIDTH);
    end

    logic [WIDTH-1:0] q_r;
    logic             load_err_r;
    logic [WIDTH-1:0] next_q;
    logic             tc;
    logic             load_over;
    logic             count_en;

    modn_next_calc #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .q      (q_r),
        .up     (Up),
        .enable (Enable),
        .ci     (CI),
        .load   (Load),
        .next_q (next_q),
        .tc     (tc)
    );

    // Out-of-range load detect; the compare carries a spare bit for MODULUS = 2**WIDTH.
    assign load_over = ({1'b0, P} >= MOD_EXT);
    assign count_en  = Enable & CI;

    // Count register: load beats count beats hold; Load_err pulses for one cycle.
    always_ff @(posedge CLK or negedge MR_N) begin
        if (!MR_N) begin
            q_r        <= '0;
            load_err_r <= 1'b0;
        end else begin
            load_err_r <= 1'b0;
            if (Load) begin
                q_r        <= load_over ? Q_MAX : P;
                load_err_r <= load_over;
            end else if (count_en) begin
                q_r <= next_q;
            end
        end
    end

`ifdef MODN_STICKY_OVF_EN
    logic ovf_r;

    // Sticky wrap flag; a wrap on the same edge as a clear keeps it set.
    always_ff @(posedge CLK or negedge MR_N) begin
        if (!MR_N) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= tc | (ovf_r & ~Ovf_clr);
        end
    end

    assign Ovf = ovf_r;
`endif

    assign Q        = q_r;
    assign TC       = tc;
    assign Load_err = load_err_r;

endmodule

// File: doc/modn_updown_counter.md
Name: modn_updown_counter

Overview:
Parametrised successor to the team's decade counter. It is a modulo-MODULUS up/down counter with a synchronous parallel load, count enable and carry-in. It drives a combinational terminal-count output so that instances cascade into multi-digit counters. Used as a digit/timebase building block wherever a loadable wrap-around count is needed.

Parameters:
- WIDTH, 4: width of Q and P in bits.
- MODULUS, 10: count range is 0..MODULUS-1.
  - Legal range: 2 <= MODULUS <= 2**WIDTH.
  - Elaboration-time check: a fatal error if out of range.

Ports:
- CLK, input, 1: single clock; all state updates on its rising edge.
- MR_N, input, 1: master reset. Asynchronous, active-low.
- Load, input, 1: synchronous parallel load request.
- P, input, WIDTH: load value.
- Enable, input, 1: count enable.
- CI, input, 1: carry/count-in for cascading. Tie to 1 for a standalone counter.
- Up, input, 1: direction. 1 = increment, 0 = decrement.
- Q, output, WIDTH: registered count value.
- TC, output, 1: terminal count, combinational.
- Load_err, output, 1: registered one-cycle pulse flagging an out-of-range load.

Behaviour:
- Clocking and reset:
  - One clock (CLK). Reset is asynchronous and active-low (MR_N).
  - MR_N low forces Q=0 and Load_err=0 immediately, independent of CLK, and holds them there while low.
  - The first active edge after MR_N rises behaves normally.
- Priority each rising CLK edge: Load > count > hold.
- Load=1:
  - P < MODULUS: Q <= P exactly (no offset).
  - P >= MODULUS: Q <= MODULUS-1 (clamp) and Load_err <= 1.
  - Enable, CI and Up are ignored in a load cycle.
- Count, when Load=0 and Enable=1 and CI=1:
  - Up=1: Q <= (Q==MODULUS-1) ? 0 : Q+1.
  - Up=0: Q <= (Q==0) ? MODULUS-1 : Q-1.
- Otherwise Q holds.
- Load_err is 0 on every edge that does not perform an out-of-range load, so it is a one-cycle pulse.
- TC = Enable & CI & ~Load & (Up ? Q==MODULUS-1 : Q==0).
  - TC is asserted in the cycle before the wrap edge.
  - TC feeds the next stage's CI, giving a ripple-free synchronous cascade.
- Arithmetic:
  - Next-state arithmetic is done in WIDTH+1 bits so that MODULUS = 2**WIDTH does not overflow.
  - The result is truncated to WIDTH bits.
- Latency: Q reflects a load or count one cycle after the qualifying edge.
- Up may change every cycle; direction is sampled on the same edge as the count.
- Reset mid-operation: an in-flight load or count is lost. Q=0 whatever the inputs are.

Optional Feature:
- Macro: MODN_STICKY_OVF_EN.
- Defined:
  - Adds input Ovf_clr (1 bit) and output Ovf (1 bit, registered).
  - Ovf is set on any counting edge where TC=1, i.e. on a wrap in either direction.
  - Ovf stays set until the first edge with Ovf_clr=1, or until MR_N is low.
  - If set and clear occur on the same edge, set wins.
  - Reset value is 0.
- Not defined: both ports and the Ovf state are absent. All other behaviour is identical.

Decomposition:
- Package modn_counter_pkg holds:
  - typedef enum logic {DIR_DOWN=1'b0, DIR_UP=1'b1} dir_e;
  - function modn_next(q, up, modulus), returning the wrapped next value.
  - The function is shared by the RTL and the bench reference model.
- Sub-module modn_next_calc:
  - Purely combinational next-count calculation plus TC detect.
  - Lets a multi-digit wrapper reuse it.
- Top level: holds the registers, the load clamp and the optional sticky flag.

Test Plan:
1. Reset: MR_N low at 3 ns, mid-cycle, with Q=7 -> Q=0 and Load_err=0 within the same cycle, without waiting for CLK; Q stays 0 while MR_N is low.
2. Up wrap (WIDTH=4, MODULUS=10): Enable=1, CI=1, Up=1 from Q=0.
   - Q runs 0..9, then 0 on the 10th edge.
   - TC=1 only while Q=9.
3. Down wrap: Up=0 from Q=1 -> Q goes 0, then 9; TC=1 only while Q=0.
4. Loads:
   - Load=1, P=7 -> Q=7 on the next edge; Load_err=0.
   - Load=1, P=12 -> Q=9; Load_err=1 for exactly one cycle.
   - Load=1 together with Enable=1 -> the load wins and TC=0.
5. Gating: Enable=0 or CI=0 for 5 edges from Q=4 -> Q holds 4 and TC=0.
   - Two-stage cascade (units TC -> tens CI): 99 -> 00 on a single edge.
6. With MODN_STICKY_OVF_EN defined:
   - Wrap 9->0 -> Ovf=1 and held for 20 edges.
   - Ovf_clr=1 -> Ovf=0.
   - Ovf_clr=1 coincident with a wrap -> Ovf stays 1.
